msg_serializer: RTL and testbench

- Sits directly downstream of msg_parser.
- Buffers the parallel messages that msg_parser emits: msg_valid pulse with msg_length, msg_data and msg_error. msg_parser has no output backpressure.
- Re-emits each message as a standalone 64-bit AXI-Stream packet, payload only, one packet per message.
- Lets a back-pressuring consumer (DMA, host FIFO) attach to the parser without losing messages silently.

---
 rtl/msg_pkg.sv | 32 +++
 rtl/msg_fifo.sv | 65 ++++++
 rtl/msg_serializer.sv | 167 ++++++++++++++++
 tb/tb_msg_serializer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_pkg.sv
// Shared types and helpers for the message serializer: the buffered message
// entry, the AXI-Stream beat width and the last-beat byte-enable helper.
package msg_pkg;

  localparam int MSG_MAX_BYTES   = 32;
  localparam int MSG_DATA_W      = 8 * MSG_MAX_BYTES;
  localparam int AXIS_DATA_BYTES = 8;
  localparam int AXIS_DATA_W     = 8 * AXIS_DATA_BYTES;
  localparam int BEAT_CNT_W      = 13;

  typedef struct packed {
    logic [15:0]           len;
    logic [MSG_DATA_W-1:0] data;
    logic                  err;
  } msg_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  // Byte enables of a packet's final beat; a zero remainder means a full beat.
  function automatic logic [7:0] keep_from_rem(input logic [2:0] rem);
    logic [7:0] keep;
    keep = 8'hFF;
    if (rem != 3'd0) begin
      keep = (8'd1 << rem) - 8'd1;
    end
    return keep;
  endfunction

endpackage

// File: rtl/msg_fifo.sv
// Single-clock FIFO of msg_entry_t with a registered full flag, an empty flag
// and an occupancy count; head entry is presented combinationally.
module msg_fifo
  import msg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  msg_entry_t               din_i,
  input  logic                     pop_i,
  output msg_entry_t               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  msg_entry_t       mem_q [DEPTH];
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d;
  logic             push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = full_q;
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign dout_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers carry one extra bit so full and empty differ; they wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (push_ok ? CNT_W'(1) : CNT_W'(0));
    rd_ptr_d = rd_ptr_q + (pop_ok ? CNT_W'(1) : CNT_W'(0));
    full_d   = ((wr_ptr_d - rd_ptr_d) == CNT_W'(DEPTH));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are
  // valid, and leaving the array reset-free lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/msg_serializer.sv
// Buffers parallel msg_parser messages and replays each as a 64-bit
// AXI-Stream packet. Define MSG_SERIALIZER_DROP_ERR_EN to discard errored messages.
module msg_serializer
  import msg_pkg::*;
#(
  parameter int MAX_MSG_BYTES = MSG_MAX_BYTES,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       msg_valid,
  input  logic [15:0]                msg_length,
  input  logic [8*MAX_MSG_BYTES-1:0] msg_data,
  input  logic                       msg_error,
  output logic [63:0]                m_tdata,
  output logic [7:0]                 m_tkeep,
  output logic                       m_tlast,
  output logic                       m_tuser,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       fifo_full,
  output logic [15:0]                drop_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  msg_entry_t             entry_in;
  msg_entry_t             head;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic                   accept, push, drop, pop, load;
  logic                   len_over;

  ser_state_e             state_q, state_d;
  logic [MSG_DATA_W-1:0]  data_q, data_d;
  logic [BEAT_CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [BEAT_CNT_W-1:0]  head_beats;
  logic [2:0]             rem_q, rem_d;
  logic                   err_q, err_d;
  logic [15:0]            drop_count_q;

  // Ingress: clamp oversize messages and flag them as errored.
  // NOTE: every signal driven in always_comb gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    len_over      = (msg_length > 16'(MAX_MSG_BYTES));
    entry_in.len  = len_over ? 16'(MAX_MSG_BYTES) : msg_length;
    entry_in.data = msg_data;
    entry_in.err  = msg_error | len_over;
`ifdef MSG_SERIALIZER_DROP_ERR_EN
    accept        = (msg_length != 16'd0) && !entry_in.err;
`else
    accept        = (msg_length != 16'd0);
`endif
  end

  // Full is the registered pre-edge flag, so a same-cycle pop cannot rescue a push.
  assign push = msg_valid && accept && !fifo_full;
  assign drop = msg_valid && !push;

  msg_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (entry_in),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_beats = BEAT_CNT_W'((17'(head.len) + 17'd7) >> 3);

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    beat_cnt_d = beat_cnt_q;
    rem_d      = rem_q;
    err_d      = err_q;
    pop        = 1'b0;
    load       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (m_tready) begin
          if (beat_cnt_q != '0) begin
            data_d     = data_q >> AXIS_DATA_W;
            beat_cnt_d = beat_cnt_q - BEAT_CNT_W'(1);
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Loading on the last handshake gives zero-bubble back-to-back packets.
    if (load) begin
      pop        = 1'b1;
      data_d     = head.data;
      beat_cnt_d = head_beats - BEAT_CNT_W'(1);
      rem_d      = head.len[2:0];
      err_d      = head.err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      beat_cnt_q <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      beat_cnt_q <= beat_cnt_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count_q <= '0;
    end else if (drop && (drop_count_q != 16'hFFFF)) begin
      drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign drop_count = drop_count_q;
  assign m_tvalid   = (state_q == ST_SEND);
  assign m_tlast    = m_tvalid && (beat_cnt_q == '0);
  assign m_tkeep    = !m_tvalid ? 8'h00 :
                      (beat_cnt_q == '0) ? keep_from_rem(rem_q) : 8'hFF;

`ifdef MSG_SERIALIZER_DROP_ERR_EN
  assign m_tuser = 1'b0;
`else
  assign m_tuser = m_tvalid && err_q;
`endif

  // Disabled byte lanes are forced to zero so stale payload never leaks out.
  always_comb begin
    m_tdata = '0;
    for (int j = 0; j < AXIS_DATA_BYTES; j++) begin
      if (m_tkeep[j]) begin
        m_tdata[8*j +: 8] = data_q[8*j +: 8];
      end
    end
  end

  fifo_count_bound_a: assert property (@(posedge clk) disable iff (rst)
    fifo_count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_msg_serializer.sv
// Scoreboard bench for msg_serializer: expected beats are queued when a
// message is driven and compared as the DUT hands them off.
module tb_msg_serializer;

  localparam int MAXB  = 32;
  localparam int DEPTH = 4;
`ifdef MSG_SERIALIZER_DROP_ERR_EN
  localparam bit DROP_ERR = 1'b1;
`else
  localparam bit DROP_ERR = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                msg_valid;
  logic [15:0]         msg_length;
  logic [8*MAXB-1:0]   msg_data;
  logic                msg_error;
  logic [63:0]         m_tdata;
  logic [7:0]          m_tkeep;
  logic                m_tlast;
  logic                m_tuser;
  logic                m_tvalid;
  logic                m_tready;
  logic                fifo_full;
  logic [15:0]         drop_count;

  beat_t exp_q[$];
  beat_t mon_act;
  beat_t mon_exp;
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    hs_count = 0;
  int    pkt_count = 0;
  int    first_hs_cyc = 0;
  int    last_hs_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  msg_serializer #(
    .MAX_MSG_BYTES (MAXB),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .msg_valid  (msg_valid),
    .msg_length (msg_length),
    .msg_data   (msg_data),
    .msg_error  (msg_error),
    .m_tdata    (m_tdata),
    .m_tkeep    (m_tkeep),
    .m_tlast    (m_tlast),
    .m_tuser    (m_tuser),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .fifo_full  (fifo_full),
    .drop_count (drop_count)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_val(input int base, input int i);
    return 8'(base + i);
  endfunction

  // Reference model: walks the payload byte by byte into 8-byte beats.
  task automatic expect_msg(input int len, input bit err, input int base);
    int    eff;
    bit    eerr;
    int    nb;
    beat_t b;
    eff  = (len > MAXB) ? MAXB : len;
    eerr = err || (len > MAXB);
    nb   = (eff + 7) / 8;
    for (int k = 0; k < nb; k++) begin
      b = '0;
      for (int j = 0; j < 8; j++) begin
        if (8*k + j < eff) begin
          b.data[8*j +: 8] = byte_val(base, 8*k + j);
          b.keep[j]        = 1'b1;
        end
      end
      b.last = (k == nb - 1);
      b.user = DROP_ERR ? 1'b0 : eerr;
      exp_q.push_back(b);
    end
  endtask

  // Strobes one message; bytes past the length carry filler that must never appear.
  task automatic send_msg(input int len, input bit err, input int base, input bit accept);
    msg_valid  = 1'b1;
    msg_length = 16'(len);
    msg_error  = err;
    for (int i = 0; i < MAXB; i++) begin
      msg_data[8*i +: 8] = (i < len) ? byte_val(base, i) : 8'hEE;
    end
    if (accept) expect_msg(len, err, base);
    @(posedge clk); #1;
    msg_valid = 1'b0;
    msg_error = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_drained"}, 96'(exp_q.size() == 0 && !m_tvalid), 96'd1);
    exp_q.delete();
  endtask

  task automatic wait_tvalid(input string tag, input int budget);
    int n;
    n = 0;
    while (!m_tvalid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_tvalid_seen"}, 96'(m_tvalid), 96'd1);
  endtask

  // Monitor: a beat counts when tvalid and tready are both high ahead of the edge.
  always @(negedge clk) begin
    if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
      mon_act = {m_tdata, m_tkeep, m_tlast, m_tuser};
      if (hs_count == 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
      hs_count++;
      if (m_tlast) pkt_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 96'(mon_act), 96'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("beat", 96'(mon_act), 96'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         drop0;
    int         lens[6];
    logic [63:0] snap_data;
    logic [7:0]  snap_keep;
    logic        snap_last;
    bit          stable;

    lens = '{8, 16, 3, 24, 5, 9};
    rst        = 1'b1;
    msg_valid  = 1'b0;
    msg_length = '0;
    msg_data   = '0;
    msg_error  = 1'b0;
    m_tready   = 1'b0;
    #3;
    check("reset_outputs",
          96'({m_tdata, m_tkeep, m_tlast, m_tuser, m_tvalid, fifo_full, drop_count}), 96'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single 13-byte message: two beats, valid two cycles after the strobe.
    m_tready = 1'b1;
    hs_count = 0;
    send_msg(13, 1'b0, 1, 1'b1);
    check("t1_tvalid_after_e0", 96'(m_tvalid), 96'd0);
    @(posedge clk); #1;
    check("t1_tvalid_after_e1", 96'(m_tvalid), 96'd1);
    check("t1_beat0_tdata", 96'(m_tdata), 96'h0807060504030201);
    wait_drain("t1", 50);
    check("t1_beats", 96'(hs_count), 96'd2);

    // Back-to-back 8 then 32 bytes: five beats with no idle cycle.
    hs_count  = 0;
    pkt_count = 0;
    send_msg(8, 1'b0, 8'h20, 1'b1);
    send_msg(32, 1'b0, 8'h40, 1'b1);
    wait_drain("t2", 50);
    check("t2_beats", 96'(hs_count), 96'd5);
    check("t2_packets", 96'(pkt_count), 96'd2);
    check("t2_no_bubble", 96'(last_hs_cyc - first_hs_cyc), 96'd4);

    // Stall beat 1 of a 24-byte message for ten cycles.
    m_tready = 1'b0;
    hs_count = 0;
    send_msg(24, 1'b0, 8'h60, 1'b1);
    wait_tvalid("t3", 20);
    m_tready = 1'b1;
    @(posedge clk); #1;
    m_tready  = 1'b0;
    snap_data = m_tdata;
    snap_keep = m_tkeep;
    snap_last = m_tlast;
    stable    = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (m_tdata !== snap_data || m_tkeep !== snap_keep ||
          m_tlast !== snap_last || m_tvalid !== 1'b1) stable = 1'b0;
    end
    check("t3_stall_stable", 96'(stable), 96'd1);
    check("t3_stall_hs", 96'(hs_count), 96'd1);
    m_tready = 1'b1;
    wait_drain("t3", 50);
    check("t3_beats", 96'(hs_count), 96'd3);

    // Overflow with the consumer stalled: the first message moves straight into
    // the shift register, so four more fill the FIFO and only the sixth drops.
    m_tready  = 1'b0;
    pkt_count = 0;
    drop0     = int'(drop_count);
    for (int i = 0; i < 6; i++) begin
      send_msg(lens[i], 1'b0, 16 * i + 3, i < 5);
      if (i == 3) check("t4_not_full_after_4", 96'(fifo_full), 96'd0);
      if (i == 4) check("t4_full_after_5", 96'(fifo_full), 96'd1);
    end
    check("t4_drops", 96'(int'(drop_count) - drop0), 96'd1);
    m_tready = 1'b1;
    wait_drain("t4", 100);
    check("t4_packets", 96'(pkt_count), 96'd5);
    check("t4_full_cleared", 96'(fifo_full), 96'd0);

    // Edge lengths and error flag.
    drop0 = int'(drop_count);
    send_msg(0, 1'b0, 8'h70, 1'b0);
    check("t5_len0_drop", 96'(int'(drop_count) - drop0), 96'd1);
    hs_count = 0;
    send_msg(40, 1'b0, 8'h80, !DROP_ERR);
    wait_drain("t5_len40", 50);
    check("t5_len40_beats", 96'(hs_count), DROP_ERR ? 96'd0 : 96'd4);
    check("t5_len40_drop", 96'(int'(drop_count) - drop0), DROP_ERR ? 96'd2 : 96'd1);
    hs_count = 0;
    send_msg(5, 1'b1, 8'hA0, !DROP_ERR);
    wait_drain("t5_err", 50);
    check("t5_err_beats", 96'(hs_count), DROP_ERR ? 96'd0 : 96'd1);
    check("t5_err_drop", 96'(int'(drop_count) - drop0), DROP_ERR ? 96'd3 : 96'd1);

    // Reset during beat 1 of a four-beat packet.
    m_tready = 1'b0;
    send_msg(32, 1'b0, 8'hC0, 1'b1);
    wait_tvalid("t6", 20);
    m_tready = 1'b1;
    @(posedge clk); #1;
    m_tready = 1'b0;
    check("t6_mid_packet", 96'({m_tvalid, m_tlast}), 96'b10);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_reset_outputs",
          96'({m_tdata, m_tkeep, m_tlast, m_tuser, m_tvalid, fifo_full, drop_count}), 96'd0);
    exp_q.delete();
    hs_count = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst      = 1'b0;
    m_tready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t6_silent_after_reset", 96'({hs_count[7:0], m_tvalid, fifo_full}), 96'd0);
    send_msg(13, 1'b0, 1, 1'b1);
    wait_drain("t6_resume", 50);
    check("t6_resume_beats", 96'(hs_count), 96'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
